// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Read-data value returned with write (and rejected) responses.
    localparam logic [31:0] WRITE_RESP_DATA = 32'h0000_0000;

    // Width of the word index for a storage array of the given depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, and a
// synchronous clear of every word (and the read register) on reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage update and registered read; reset wins over any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
            rdata <= 32'h0;
        end else begin
            if (we) begin
                mem[index] <= wdata;
            end
            if (re) begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the pipeline data-memory interface. Accepts one request
// at a time, services it after LATENCY cycles and holds the response until
// the requester takes it.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned
// requests (no access, respError = 1); otherwise reqAddress[1:0] is ignored.
//
// state | meaning
// IDLE  | reqReady high, waiting for a request
// BUSY  | access latency countdown; access made when the counter is 0
// RESP  | response presented, held until respReady
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqWriteData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respReadData,
    output logic        respError
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               wr_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata;
    logic               accept;
    logic               access;
    logic               addr_err;

    // Address bits above the array and, without the alignment check, the
    // byte offset do not take part in the access.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reqAddress[31:IDX_W+2], reqAddress[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_err = |reqAddress[1:0];
`else
    assign addr_err = 1'b0;
`endif

    assign accept = (state == IDLE) && reqValid;
    assign access = (state == BUSY) && (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        reqReady   = 1'b0;
        respValid  = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                respValid = 1'b1;
                if (respReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and latency down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY - 1);
            wr_q    <= reqWrite;
            err_q   <= addr_err;
            idx_q   <= reqAddress[IDX_W+1:2];
            wdata_q <= reqWriteData;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (access && wr_q && !err_q),
        .re    (access && !wr_q && !err_q),
        .index (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // The read register holds its value until the next read, so the
    // response data stays stable through back-pressure.
    assign respReadData = (respValid && !wr_q && !err_q) ? rdata : WRITE_RESP_DATA;
    assign respError    = respValid && err_q;

endmodule
